delay_pulse_channel: RTL and testbench
======================================

# delay_pulse_channel

Single-channel delay/pulse timer for the multi-channel delay generator. It watches the shared two-bit master trigger bus `t0`. On each trigger it waits a programmable number of clocks, then drives one output pin high for a programmable number of clocks. One instance is built per output channel; all instances share the clock, reset and `t0`.

## Interface
Parameters:
- `WIDTH`, default 32: bit width of the `delay` and `width` operands and of the internal counters.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `t0`  in  2  master trigger bus. Bit 0 is a one-clock pulse. Bit 1 is bit 0 delayed by one clock. A trigger is the value 2'b01.
- `delay`  in  WIDTH  clocks from trigger to pulse start, unsigned.
- `width`  in  WIDTH  pulse length in clocks, unsigned.
- `pinout`  out  1  registered pulse output.
- `busy`  out  1  present only with `DELAY_PULSE_BUSY_EN` (see Configuration).

## Operation
- Three states:
  - IDLE: `pinout`=0.
  - DELAY: counting down the delay; `pinout`=0.
  - PULSE: counting down the width; `pinout`=1.
- Trigger = `t0` sampled as 2'b01 on a rising edge. Values 2'b10, 2'b11 and 2'b00 are not triggers.
- On a trigger, `delay` and `width` are snapshotted into internal registers. Later changes to the inputs have no effect until the next trigger.
- Trigger with width=0: go to (or stay in) IDLE; no pulse.
- Trigger with width≠0 and delay=0: enter PULSE directly with the width counter loaded.
- Trigger with width≠0 and delay≠0: enter DELAY with the delay counter loaded.
- DELAY: decrement each clock. When the remaining count reaches zero, enter PULSE.
- PULSE: decrement each clock. When the remaining count reaches zero, return to IDLE.
- Retrigger in any state, including mid-DELAY or mid-PULSE: abort the current sequence and restart from the new snapshot. There is no queuing.
- Delay and width use separate counters. `delay`+`width` is never summed, so there is no overflow at the maximum values 2^WIDTH−1.
- `reset`: state IDLE, counters 0, snapshots 0, `pinout`=0. Reset has priority over a trigger on the same edge.

## Timing
- E0 is the rising edge that samples the trigger.
- Rising edge of `pinout`: at edge E0+`delay`. It is visible in the cycle after that edge.
- Falling edge of `pinout`: at edge E0+`delay`+`width`.
- `pinout` is high for exactly `width` clock cycles.
- delay=0: `pinout` rises at E0, one clock of latency from the trigger appearing on `t0`.
- Retrigger while `pinout`=1 and new delay≠0: `pinout` falls at the retrigger edge.
- Retrigger while `pinout`=1 and new delay=0: `pinout` stays high continuously, now for the new `width` counted from the retrigger edge.
- The trigger period is normally much longer than delay+width, but correctness does not depend on it.
- Output transitions are registered only: no combinational path from any input to `pinout`.

## Configuration
- Macro `DELAY_PULSE_BUSY_EN`.
  - Defined: output `busy` exists. It is registered, 1 in DELAY or PULSE, 0 in IDLE, 0 after reset, and changes on the same edges as the state.
  - Undefined: the `busy` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then trigger with delay=10, width=10: `pinout`=0 through edge E0+9, high at edges E0+10…E0+19, low from E0+20 onward.
- delay=0, width=1: `pinout` high for exactly one cycle, starting at E0.
- width=0, delay=5: no pulse ever. With the macro defined, `busy` stays 0.
- Change `delay`/`width` to 3/3 mid-sequence of an active 20/5 run: the current pulse still follows 20/5; the next trigger uses 3/3.
- Retrigger at E0+22 during the pulse of a delay=20, width=10 sequence, with new delay=4: `pinout` falls at E0+22, rises at E0+26, high for 10 cycles.
- Assert `reset` mid-PULSE: `pinout` is 0 after that edge. A trigger sampled on the same edge as `reset` is ignored.

Source files
------------

// File: rtl/delay_pulse_channel.sv
// One output channel of the delay generator: trigger, wait delay, pulse width.
// Optional registered busy flag is built when DELAY_PULSE_BUSY_EN is defined.
module delay_pulse_channel #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       t0,
    input  logic [WIDTH-1:0] delay,
    input  logic [WIDTH-1:0] width,
    output logic             pinout
`ifdef DELAY_PULSE_BUSY_EN
    ,
    output logic             busy
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        DLY,
        PULSE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dcnt_q, dcnt_d;
    logic [WIDTH-1:0] wcnt_q, wcnt_d;
    logic [WIDTH-1:0] wsnap_q, wsnap_d;
    logic             trig;

    assign trig = (t0 == 2'b01);

    // Counters hold "edges remaining minus one", so a zero count means this
    // edge is the last one spent in the current state.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;
        wsnap_d = wsnap_q;
        if (trig) begin
            wsnap_d = width;
            if (width == '0) begin
                state_d = IDLE;
            end else if (delay == '0) begin
                state_d = PULSE;
                wcnt_d  = width - ONE;
            end else begin
                state_d = DLY;
                dcnt_d  = delay - ONE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                DLY: begin
                    if (dcnt_q == '0) begin
                        state_d = PULSE;
                        wcnt_d  = wsnap_q - ONE;
                    end else begin
                        dcnt_d = dcnt_q - ONE;
                    end
                end
                PULSE: begin
                    if (wcnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q - ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            wcnt_q  <= '0;
            wsnap_q <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            wsnap_q <= wsnap_d;
        end
    end

    assign pinout = (state_q == PULSE);

`ifdef DELAY_PULSE_BUSY_EN
    assign busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_delay_pulse_channel.sv
// Scoreboard bench for delay_pulse_channel: a timeline model predicts pinout
// (and busy when built) per edge; a monitor pops and compares each cycle.
module tb_delay_pulse_channel;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   t0 = 2'b00;
    logic [W-1:0] delay = '0;
    logic [W-1:0] width = '0;
    logic         pinout;
`ifdef DELAY_PULSE_BUSY_EN
    logic         busy;
`endif

    delay_pulse_channel #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .t0     (t0),
        .delay  (delay),
        .width  (width),
        .pinout (pinout)
`ifdef DELAY_PULSE_BUSY_EN
        ,
        .busy   (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        bit pin;
        bit bsy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Timeline model: the most recent trigger alone defines the output.
    int   edge_n = 0;
    bit   have   = 0;
    int   t_e    = 0;
    int   md     = 0;
    int   mw     = 0;
    bit   prev_b0 = 0;

    task automatic step_raw(input bit r, input logic [1:0] tv,
                            input int d, input int w);
        exp_t x;
        @(negedge clk);
        reset   = r;
        t0      = tv;
        delay   = W'(d);
        width   = W'(w);
        prev_b0 = tv[0];
        edge_n++;
        if (r) begin
            have = 0;
        end else if (tv == 2'b01) begin
            have = 1;
            t_e  = edge_n;
            md   = d;
            mw   = w;
        end
        x.e   = edge_n;
        x.pin = have && edge_n >= t_e + md && edge_n < t_e + md + mw;
        x.bsy = have && mw != 0 && edge_n >= t_e && edge_n < t_e + md + mw;
        q.push_back(x);
    endtask

    task automatic step(input bit r, input bit b0, input int d, input int w);
        step_raw(r, {prev_b0, b0}, d, w);
    endtask

    task automatic fire(input int d, input int w);
        step(0, 1, d, w);
    endtask

    task automatic idle(input int n, input int d, input int w);
        for (int i = 0; i < n; i++) step(0, 0, d, w);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (pinout !== x.pin) begin
                    errors++;
                    $display("FAIL pinout edge=%0d got=%b exp=%b",
                             x.e, pinout, x.pin);
                end
`ifdef DELAY_PULSE_BUSY_EN
                checks++;
                if (busy !== x.bsy) begin
                    errors++;
                    $display("FAIL busy edge=%0d got=%b exp=%b",
                             x.e, busy, x.bsy);
                end
`endif
            end
        end
    end

    initial begin : driver
        int r;
        int b;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(2, 0, 0);

        fire(10, 10);
        idle(25, 10, 10);

        fire(0, 1);
        idle(5, 0, 1);

        fire(5, 0);
        idle(15, 5, 0);

        fire(20, 5);
        idle(30, 3, 3);
        fire(3, 3);
        idle(10, 3, 3);

        fire(20, 10);
        idle(21, 20, 10);
        fire(4, 10);
        idle(20, 4, 10);

        fire(2, 10);
        idle(5, 2, 10);
        step_raw(1, 2'b01, 1, 10);
        idle(15, 1, 10);

        fire(0, 10);
        idle(4, 0, 10);
        fire(0, 6);
        idle(10, 0, 6);

        fire(7, 12);
        idle(3, 7, 12);
        fire(6, 0);
        idle(20, 6, 0);

        fire(255, 255);
        idle(520, 255, 255);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            b = $urandom_range(0, 99);
            if (r < 1) begin
                step(1, ($urandom_range(0, 1) == 1),
                     $urandom_range(0, 25), $urandom_range(0, 25));
            end else if (r < 3) begin
                step_raw(0, 2'($urandom_range(0, 3)),
                         $urandom_range(0, 25), $urandom_range(0, 25));
            end else begin
                step(0, (b < 5), $urandom_range(0, 25),
                     $urandom_range(0, 25));
            end
        end
        idle(60, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
